switch_ramp_gen: RTL and testbench

Sequential stimulus generator driving the seven switch lines (a..g) consumed by the 7-input switch counter. Given a 3-bit target count, it moves the switch bank one switch at a time, at a fixed step interval, until exactly that many switches are on. Set switches always form a thermometer pattern starting at switch a. A start/busy/done handshake lets a sequencer chain targets and check the counter's 3-bit output against `level` after each `done`.

---
 rtl/switch_ramp_gen.sv | 104 ++++++++++
 tb/tb_switch_ramp_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/switch_ramp_gen.sv
// Ramps a 7-line thermometer switch bank one switch per step toward a latched
// target count, with a start/busy/done handshake for sequencing.
module switch_ramp_gen #(
  parameter int STEP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] target,
  output logic [6:0] sw,
  output logic [2:0] level,
  output logic       busy,
  output logic       done
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    tgt_q, tgt_d;
  logic [2:0]    level_q, level_d;
  logic [6:0]    sw_q, sw_d;
  logic [TW-1:0] timer_q, timer_d;

  // Handshake: start is sampled only in IDLE; busy covers CHECK and WAIT;
  // done is a single-cycle pulse in DONE that coincides with busy falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= 3'd0;
      level_q <= 3'd0;
      sw_q    <= 7'h00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      level_q <= level_d;
      sw_q    <= sw_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    level_d = level_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_d   = target;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (level_q == tgt_q) begin
          state_d = ST_DONE;
        end else begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TIMER_LAST) begin
          // A step only happens when level != tgt, so it never wraps.
          if (level_q < tgt_q) begin
            level_d = level_q + 3'd1;
          end else if (level_q > tgt_q) begin
            level_d = level_q - 3'd1;
          end
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Switch i is on iff i < level; level moves by one, so sw moves one line.
  always_comb begin
    sw_d = 7'h00;
    for (int i = 0; i < 7; i++) begin
      sw_d[i] = (3'(i) < level_d);
    end
  end

  assign sw    = sw_q;
  assign level = level_q;
  assign busy  = (state_q == ST_CHECK) || (state_q == ST_WAIT);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_switch_ramp_gen.sv
// Directed bench for switch_ramp_gen: table of ramp requests checked cycle by
// cycle against a step-timing model, plus reset and STEP_CYCLES=1 sequences.
module tb_switch_ramp_gen;

  localparam int S = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] target;
  logic [6:0] sw;
  logic [2:0] level;
  logic       busy;
  logic       done;

  logic       start1;
  logic [2:0] target1;
  logic [6:0] sw1;
  logic [2:0] level1;
  logic       busy1;
  logic       done1;

  int n_tests;
  int n_fail;
  int lvl_cur;

  typedef struct {
    logic [2:0] tgt;
    bit         pulse_mid;
    bit         pulse_done;
    int         exp_done;
    logic [6:0] exp_sw;
  } vec_t;

  vec_t vecs[6];

  switch_ramp_gen #(.STEP_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .sw(sw), .level(level), .busy(busy), .done(done)
  );

  switch_ramp_gen #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .target(target1),
    .sw(sw1), .level(level1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] thermo(input int l);
    logic [6:0] r;
    r = 7'h00;
    for (int i = 0; i < 7; i++) if (i < l) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int popcnt(input logic [6:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 7; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request and check {sw,level,busy,done} every cycle until the
  // cycle after DONE; optional extra start pulses must be ignored.
  task automatic run_vec(input vec_t v, input int idx);
    int n, dir, steps, lvl, seen_done, last;
    logic [11:0] exp_v;
    n    = (int'(v.tgt) > lvl_cur) ? int'(v.tgt) - lvl_cur : lvl_cur - int'(v.tgt);
    dir  = (int'(v.tgt) > lvl_cur) ? 1 : -1;
    last = n * (S + 1) + 2;
    seen_done = -1;
    @(negedge clk);
    start  = 1'b1;
    target = v.tgt;
    @(posedge clk);
    #1 start = 1'b0;
    target = 3'($urandom_range(0, 7));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (v.pulse_mid && c == 3) begin
        start = 1'b1; target = 3'd0;
      end
      if (v.pulse_done && c == last - 1) begin
        start = 1'b1; target = 3'd0;
      end
      steps = c / (S + 1);
      if (steps > n) steps = n;
      lvl = lvl_cur + dir * steps;
      exp_v = {thermo(lvl), 3'(lvl), (c >= 1 && c <= n * (S + 1)), (c == n * (S + 1) + 1)};
      chk($sformatf("v%0d_c%0d", idx, c), 32'({sw, level, busy, done}), 32'(exp_v));
      if (done && seen_done < 0) seen_done = c;
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), 32'(seen_done), 32'(v.exp_done));
    chk($sformatf("v%0d_final_sw", idx), 32'(sw), 32'(v.exp_sw));
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    lvl_cur = int'(v.tgt);
  endtask

  initial begin
    vec_t v2;
    int seen;
    n_tests = 0;
    n_fail  = 0;
    lvl_cur = 0;
    start   = 1'b0;
    target  = 3'd0;
    start1  = 1'b0;
    target1 = 3'd0;

    vecs[0] = '{tgt: 3'd7, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 36, exp_sw: 7'h7F};
    vecs[1] = '{tgt: 3'd3, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 21, exp_sw: 7'h07};
    vecs[2] = '{tgt: 3'd3, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 1,  exp_sw: 7'h07};
    vecs[3] = '{tgt: 3'd0, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 16, exp_sw: 7'h00};
    vecs[4] = '{tgt: 3'd7, pulse_mid: 1'b1, pulse_done: 1'b1, exp_done: 36, exp_sw: 7'h7F};
    vecs[5] = '{tgt: 3'd0, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 36, exp_sw: 7'h00};

    // Reset state
    rst_n = 1'b0;
    #3;
    chk("reset_outputs", 32'({sw, level, busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'({sw, level, busy, done}), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Async reset mid-WAIT while ramping up at level 4
    @(negedge clk);
    start = 1'b1; target = 3'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("pre_reset_level", 32'({sw, level, busy}), 32'({7'h0F, 3'd4, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_now", 32'({sw, level, busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lvl_cur = 0;
    v2 = '{tgt: 3'd2, pulse_mid: 1'b0, pulse_done: 1'b0, exp_done: 11, exp_sw: 7'h03};
    run_vec(v2, 6);

    // STEP_CYCLES = 1 instance: target 5 from 0
    seen = -1;
    @(negedge clk);
    start1 = 1'b1; target1 = 3'd5;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      int st;
      @(posedge clk);
      #1;
      st = c / 2;
      if (st > 5) st = 5;
      chk($sformatf("s1_c%0d_sw", c), 32'(sw1), 32'(thermo(st)));
      chk($sformatf("s1_c%0d_pop", c), 32'(level1), 32'(popcnt(sw1)));
      if (done1 && seen < 0) seen = c;
    end
    chk("s1_done_cycle", 32'(seen), 32'd11);
    chk("s1_final_level", 32'(level1), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
